if_fetch_unit: RTL and testbench

// - Instruction-fetch stage directly downstream of the PC/nPC registers, upstream of decode (ID).
// - Samples the current PC, fetches one word from instruction memory over a req/ack handshake,

---
 rtl/if_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: samples the PC, fetches one word over a req/ack handshake and
// queues {pc, instr} pairs for decode. A flush drops queued work and any fetch in flight.
module if_fetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [ADDR_W-1:0]        pc_in,
    output logic                     pc_le,
    output logic                     fetch_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_ack,
    input  logic [INSTR_W-1:0]       imem_data,
    input  logic                     flush,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [INSTR_W-1:0]       id_instr,
    output logic [ADDR_W-1:0]        id_pc,
    output logic [$clog2(DEPTH):0]   buf_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [CNT_W-1:0]    count_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [ADDR_W-1:0]   req_pc_reg;

    logic                can_launch;
    logic                push;
    logic                pop;

    logic [ADDR_W-1:0]   entry_pc    [DEPTH];
    logic [INSTR_W-1:0]  entry_instr [DEPTH];

    assign can_launch = (count_reg < DEPTH_C);
    assign pop        = (count_reg != '0) && id_ready;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A flush while waiting cannot cancel the memory access, so the late ack is swallowed in DISCARD.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (can_launch && !flush) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_ack)   state_next = S_IDLE;
                else if (flush) state_next = S_DISCARD;
            end
            S_DISCARD: begin
                if (imem_ack) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pc_le     = 1'b0;
        fetch_req = 1'b0;
        push      = 1'b0;
        case (state_reg)
            S_IDLE:    pc_le = clr && can_launch && !flush;
            S_WAIT: begin
                fetch_req = 1'b1;
                push      = clr && imem_ack && !flush;
            end
            S_DISCARD: fetch_req = 1'b1;
            default: begin
                pc_le     = 1'b0;
                fetch_req = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            req_pc_reg <= '0;
        end else if (pc_le) begin
            req_pc_reg <= pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr || flush) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            logic [ADDR_W-1:0]  pc_reg;
            logic [INSTR_W-1:0] instr_reg;

            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    pc_reg    <= req_pc_reg;
                    instr_reg <= imem_data;
                end
            end

            assign entry_pc[gi]    = pc_reg;
            assign entry_instr[gi] = instr_reg;
        end
    endgenerate

    assign imem_addr = req_pc_reg;
    assign id_valid  = (count_reg != '0);
    assign id_pc     = entry_pc[rd_ptr_reg];
    assign id_instr  = entry_instr[rd_ptr_reg];
    assign buf_count = count_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: linear stimulus, hand-computed expectations, immediate assertions.
module tb_if_fetch_unit;

    logic        clk;
    logic        clr;
    logic [31:0] pc_in;
    logic        pc_le;
    logic        fetch_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [1:0]  buf_count;

    int vectors;
    int miscompares;

    if_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .DEPTH(2)) dut (
        .clk       (clk),
        .clr       (clr),
        .pc_in     (pc_in),
        .pc_le     (pc_le),
        .fetch_req (fetch_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .buf_count (buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clr && id_valid && id_ready)
            $display("pop  pc=%08h instr=%08h", id_pc, id_instr);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clr       = 1'b0;
        pc_in     = 32'h100;
        imem_ack  = 1'b1;
        imem_data = 32'h0;
        flush     = 1'b0;
        id_ready  = 1'b0;

        // Reset held two cycles with a stray ack present
        cyc(); cyc();
        chk("rst_fetch_req", fetch_req, 0);
        chk("rst_pc_le",     pc_le,     0);
        chk("rst_id_valid",  id_valid,  0);
        chk("rst_buf_count", buf_count, 0);
        chk("rst_imem_addr", imem_addr, 0);

        // Release with a stray ack in IDLE (launch blocked by flush): nothing may be pushed
        clr = 1'b1; flush = 1'b1;
        #1;
        chk("stray_pc_le", pc_le, 0);
        cyc();
        chk("stray_buf_count", buf_count, 0);
        chk("stray_fetch_req", fetch_req, 0);
        chk("stray_id_valid",  id_valid,  0);

        // Single fetch, ack one cycle after req
        flush = 1'b0; imem_ack = 1'b0; id_ready = 1'b1; pc_in = 32'h100;
        #1;
        chk("s2_pc_le_launch", pc_le, 1);
        cyc();
        chk("s2_fetch_req", fetch_req, 1);
        chk("s2_imem_addr", imem_addr, 32'h100);
        chk("s2_pc_le_once", pc_le, 0);
        cyc();
        chk("s2_req_held", fetch_req, 1);
        imem_ack = 1'b1; imem_data = 32'h82000001;
        cyc();
        imem_ack = 1'b0;
        #1;
        chk("s2_id_valid", id_valid,  1);
        chk("s2_id_pc",    id_pc,     32'h100);
        chk("s2_id_instr", id_instr,  32'h82000001);
        chk("s2_buf_count", buf_count, 1);
        chk("s2_fetch_idle", fetch_req, 0);

        // Entry popped while the next launch (pc 0x100) goes out; then fill the buffer
        cyc();
        id_ready = 1'b0; imem_ack = 1'b1; imem_data = 32'h11111111;
        #1;
        chk("s3_imem_addr0", imem_addr, 32'h100);
        chk("s3_count_after_pop", buf_count, 0);
        cyc();
        imem_ack = 1'b0; pc_in = 32'h104;
        #1;
        chk("s3_pc_le_second", pc_le, 1);
        chk("s3_count1", buf_count, 1);
        cyc();
        imem_ack = 1'b1; imem_data = 32'h22222222;
        #1;
        chk("s3_imem_addr1", imem_addr, 32'h104);
        cyc();
        imem_ack = 1'b0;
        #1;
        chk("s3_full_count",  buf_count, 2);
        chk("s3_full_pc_le",  pc_le,     0);
        chk("s3_full_req",    fetch_req, 0);
        cyc();
        chk("s3_hold_count",  buf_count, 2);
        chk("s3_hold_pc_le",  pc_le,     0);
        chk("s3_hold_req",    fetch_req, 0);
        id_ready = 1'b1;
        #1;
        chk("s3_head0_pc",    id_pc,    32'h100);
        chk("s3_head0_instr", id_instr, 32'h11111111);
        cyc();
        pc_in = 32'h108;
        #1;
        chk("s3_head1_pc",    id_pc,     32'h104);
        chk("s3_head1_instr", id_instr,  32'h22222222);
        chk("s3_resume_pc_le", pc_le,    1);
        chk("s3_count_drain", buf_count, 1);
        cyc();
        id_ready = 1'b0;
        #1;
        chk("s3_addr_108",   imem_addr, 32'h108);
        chk("s3_empty",      id_valid,  0);

        // Flush in WAIT, ack three cycles later is swallowed
        flush = 1'b1;
        cyc();
        flush = 1'b0; pc_in = 32'h200;
        #1;
        chk("s4_discard_req",   fetch_req, 1);
        chk("s4_discard_pc_le", pc_le,     0);
        chk("s4_discard_addr",  imem_addr, 32'h108);
        cyc(); cyc();
        imem_ack = 1'b1; imem_data = 32'hDEADBEEF;
        #1;
        chk("s4_late_req", fetch_req, 1);
        cyc();
        imem_ack = 1'b0;
        #1;
        chk("s4_no_push_count", buf_count, 0);
        chk("s4_no_push_valid", id_valid,  0);
        chk("s4_relaunch",      pc_le,     1);
        cyc();
        chk("s4_new_addr", imem_addr, 32'h200);
        chk("s4_new_req",  fetch_req, 1);

        // count=1 with flush + ack + id_ready together
        imem_ack = 1'b1; imem_data = 32'h33333333;
        cyc();
        imem_ack = 1'b0; pc_in = 32'h300;
        #1;
        chk("s5_pc_le", pc_le, 1);
        cyc();
        flush = 1'b1; imem_ack = 1'b1; id_ready = 1'b1; imem_data = 32'h44444444;
        #1;
        chk("s5_pre_count", buf_count, 1);
        chk("s5_pre_pc",    id_pc,     32'h200);
        chk("s5_pre_instr", id_instr,  32'h33333333);
        cyc();
        flush = 1'b0; imem_ack = 1'b0; id_ready = 1'b0;
        #1;
        chk("s5_flush_count", buf_count, 0);
        chk("s5_flush_valid", id_valid,  0);
        chk("s5_flush_idle",  fetch_req, 0);

        // Reset during WAIT, ack arrives after release
        cyc();
        chk("s6_wait_req", fetch_req, 1);
        clr = 1'b0;
        cyc();
        chk("s6_rst_req",   fetch_req, 0);
        chk("s6_rst_count", buf_count, 0);
        chk("s6_rst_pc_le", pc_le,     0);
        clr = 1'b1; pc_in = 32'h400; imem_ack = 1'b1; imem_data = 32'h55555555;
        #1;
        chk("s6_fresh_pc_le", pc_le, 1);
        cyc();
        imem_ack = 1'b0;
        #1;
        chk("s6_ignored_count", buf_count, 0);
        chk("s6_fresh_addr",    imem_addr, 32'h400);
        chk("s6_fresh_req",     fetch_req, 1);
        imem_ack = 1'b1; imem_data = 32'h66666666;
        cyc();
        imem_ack = 1'b0;
        #1;
        chk("s6_push_pc",    id_pc,    32'h400);
        chk("s6_push_instr", id_instr, 32'h66666666);
        chk("s6_push_count", buf_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
